lap_stopwatch: RTL and testbench
================================

// Module: lap_stopwatch
// PURPOSE
// - Parametrised single-clock stopwatch core: internal tick prescaler, NUM_DIGITS cascaded BCD digits,
//   start/stop, lap (display freeze/split) and clear-from-pause control.
// - Sits between the debounced button inputs and the seven-segment multiplexer; drives BCD digits only.
// - Replaces divided-clock counting: all logic on clk, advancing on a one-cycle tick enable.
// PARAMETERS
// - CLK_HZ      100_000_000  input clock frequency
// - TICK_HZ     10           count rate of digit 0 (10 = tenths of a second)
// - NUM_DIGITS  3            number of decimal BCD digits, >=1; digit 0 least significant
// PORTS
// - clk          in   1             system clock
// - reset        in   1             asynchronous, active-high reset
// - start_stop   in   1             debounced, synchronous level; rising edge = start/stop event
// - lap          in   1             debounced, synchronous level; rising edge = lap/clear event
// - count_bcd    out  4*NUM_DIGITS  live count, digit i in bits [4i+3:4i]
// - disp_bcd     out  4*NUM_DIGITS  value for display: live count, or frozen snapshot in LAP
// - running      out  1             1 in RUNNING or LAP
// - frozen       out  1             1 in LAP
// - wrap         out  1             one-cycle pulse when count rolls from all-9s to all-0s
// BEHAVIOUR
// - Reset: state=IDLE, count_bcd=0, disp_bcd=0, snapshot=0, prescaler=0, edge regs=0, all flags 0.
// - Edges: ev = in & ~in_q (in_q registered). State/count update on the next clk edge (1-cycle latency).
// - Prescaler: DIV=CLK_HZ/TICK_HZ; counts 0..DIV-1 only in RUNNING/LAP; tick=1 when at DIV-1.
//   Held at 0 in IDLE/PAUSED, so every resume gives a full first period.
// - Count: on tick, digit 0 +1; carry propagates while digit==9 (digit -> 0). All-9s -> all-0s,
//   wrap=1 that cycle, counting continues. Digit values never exceed 9.
// - States:
//   IDLE    : count 0.  start_stop -> RUNNING.  lap ignored.
//   RUNNING : start_stop -> PAUSED.  lap -> LAP, snapshot <= count_bcd (value after any same-cycle tick).
//   LAP     : counting continues, disp_bcd = snapshot.  lap -> RUNNING (display live).
//             start_stop -> PAUSED, display returns to live (stopped) count.
//   PAUSED  : count held.  start_stop -> RUNNING (resume).  lap -> IDLE, count and snapshot cleared.
// - Simultaneous start_stop and lap edges: start_stop wins, lap discarded.
// - Tick coincident with stop event: tick applied, then count held.
// - Levels held high cause no repeat events; new event requires low then high.
// - Reset mid-operation: everything returns to reset values immediately; no event on release
//   unless a rising edge is seen afterwards.
// STRUCTURE
// - Package stopwatch_pkg: state encoding IDLE/RUNNING/LAP/PAUSED (2-bit), BCD_W=4, BCD_MAX=4'd9.
// - Sub-module bcd_digit: one digit, inputs inc/clr, outputs q[3:0] and carry (inc & q==9);
//   instantiated NUM_DIGITS times in a generate chain; carry of last digit gives wrap.
// - Top: edge detectors, prescaler, FSM, snapshot register, disp_bcd mux.
// TESTING (CLK_HZ=100, TICK_HZ=10 -> DIV=10, NUM_DIGITS=3)
// - start_stop pulse, 990 clks -> count_bcd=12'h099; 10 more -> 12'h100, running=1, wrap=0.
// - Run to 12'h999, next tick -> 12'h000, wrap high exactly 1 cycle, running stays 1.
// - At count 12'h053 press lap -> disp_bcd=12'h053 frozen, count_bcd keeps advancing; lap again -> disp=live.
// - Run, stop at 12'h027, wait 50 clks -> unchanged; lap -> count=0, IDLE; resume: first tick after 10 clks.
// - start_stop and lap rise same cycle in RUNNING -> PAUSED, frozen=0, snapshot unchanged.
// - Assert reset in LAP at 12'h314 -> all outputs 0 without clk edge; buttons held high during
//   release -> no event until re-pressed.

Source files
------------

// File: rtl/lap_stopwatch_pkg.sv
// Shared constants and types for the lap stopwatch: FSM state encoding,
// BCD digit limits and a prescaler width helper.
package lap_stopwatch_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RUNNING = 2'd1;
  localparam state_t ST_LAP     = 2'd2;
  localparam state_t ST_PAUSED  = 2'd3;

  // Width of a counter that spans 0..div-1; at least one bit so DIV=1 still elaborates.
  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/lap_stopwatch_if.sv
// Button inputs and BCD/status outputs of the stopwatch core, bundled as one port.
interface lap_stopwatch_if #(
  parameter int NUM_DIGITS = 3
);

  logic                    start_stop;
  logic                    lap;
  logic [4*NUM_DIGITS-1:0] count_bcd;
  logic [4*NUM_DIGITS-1:0] disp_bcd;
  logic                    running;
  logic                    frozen;
  logic                    wrap;

  // Button side drives the levels and watches the results.
  modport master (
    output start_stop,
    output lap,
    input  count_bcd,
    input  disp_bcd,
    input  running,
    input  frozen,
    input  wrap
  );

  modport slave (
    input  start_stop,
    input  lap,
    output count_bcd,
    output disp_bcd,
    output running,
    output frozen,
    output wrap
  );

endinterface

// File: rtl/lap_stopwatch_bcd_digit.sv
// One decade of the BCD count chain: increments on inc, rolls 9 -> 0 and
// raises carry for the next digit in the same cycle.
module lap_stopwatch_bcd_digit
  import lap_stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] q,
  output logic [BCD_W-1:0] nxt,
  output logic             carry
);

  logic at_max;

  assign at_max = (q == BCD_MAX);
  assign carry  = inc & at_max;

  // nxt is exported so the parent can capture the post-tick value in the same cycle.
  always_comb begin
    nxt = q;
    if (clr)
      nxt = '0;
    else if (inc)
      nxt = at_max ? '0 : q + 4'd1;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values, like the hardware.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else
      q <= nxt;
  end

endmodule

// File: rtl/lap_stopwatch.sv
// Stopwatch core: button edge detection, tick prescaler, run/lap/pause FSM,
// cascaded BCD digits, lap snapshot and display select, all on one clock.
module lap_stopwatch
  import lap_stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 10,
  parameter int NUM_DIGITS = 3
) (
  input  logic           clk,
  input  logic           reset,
  lap_stopwatch_if.slave bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = presc_width(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam int CW  = 4 * NUM_DIGITS;

  state_t          state;
  state_t          state_nxt;
  logic            ss_q;
  logic            lap_q;
  logic            armed;
  logic            ss_ev;
  logic            lap_ev;
  logic            active;
  logic            tick;
  logic            clr;
  logic            snap_load;
  logic [PW-1:0]   presc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic [CW-1:0]   snapshot;
  logic [NUM_DIGITS:0] carry;
  logic            wrap_q;

  // armed stays low for the first edge after reset, so a button already held
  // high during reset release only loads its history and never fires an event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_q  <= 1'b0;
      lap_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      ss_q  <= bus.start_stop;
      lap_q <= bus.lap;
      armed <= 1'b1;
    end
  end

  assign ss_ev  = armed & bus.start_stop & ~ss_q;
  assign lap_ev = armed & bus.lap & ~lap_q;

  assign active = (state == ST_RUNNING) || (state == ST_LAP);
  assign tick   = active && (presc == PRESC_MAX);

  // Held at zero outside RUNNING/LAP so each resume starts a full tick period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      presc <= '0;
    else if (!active || tick)
      presc <= '0;
    else
      presc <= presc + 1'b1;
  end

  // start_stop is tested first in every state, so it wins over a coincident lap.
  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    snap_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ss_ev)
          state_nxt = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (ss_ev) begin
          state_nxt = ST_PAUSED;
        end else if (lap_ev) begin
          state_nxt = ST_LAP;
          snap_load = 1'b1;
        end
      end
      ST_LAP: begin
        if (ss_ev)
          state_nxt = ST_PAUSED;
        else if (lap_ev)
          state_nxt = ST_RUNNING;
      end
      ST_PAUSED: begin
        if (ss_ev) begin
          state_nxt = ST_RUNNING;
        end else if (lap_ev) begin
          state_nxt = ST_IDLE;
          clr       = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  assign carry[0] = tick;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    lap_stopwatch_bcd_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .inc   (carry[g]),
      .clr   (clr),
      .q     (count[4*g +: 4]),
      .nxt   (count_nxt[4*g +: 4]),
      .carry (carry[g+1])
    );
  end

  // Snapshot takes count_nxt so a tick landing on the lap edge is included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      snapshot <= '0;
    else if (clr)
      snapshot <= '0;
    else if (snap_load)
      snapshot <= count_nxt;
  end

  // Registered so the pulse lines up with the cycle the count reads all zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wrap_q <= 1'b0;
    else
      wrap_q <= carry[NUM_DIGITS];
  end

  assign bus.count_bcd = count;
  assign bus.disp_bcd  = (state == ST_LAP) ? snapshot : count;
  assign bus.running   = active;
  assign bus.frozen    = (state == ST_LAP);
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch (DIV=10, three digits): expected outputs are
// queued as each step is driven and compared once the step has been clocked.
module tb_lap_stopwatch;

  localparam int ND = 3;

  typedef struct {
    string         tag;
    logic [11:0]   count;
    logic [11:0]   disp;
    logic          running;
    logic          frozen;
    logic          wrap;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];

  lap_stopwatch_if #(.NUM_DIGITS(ND)) bus ();

  lap_stopwatch #(
    .CLK_HZ     (100),
    .TICK_HZ    (10),
    .NUM_DIGITS (ND)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_ss();
    bus.start_stop = 1'b1;
    step(1);
    bus.start_stop = 1'b0;
  endtask

  task automatic press_lap();
    bus.lap = 1'b1;
    step(1);
    bus.lap = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [11:0] c, input logic [11:0] d,
                            input logic r, input logic f, input logic w);
    exp_t e;
    e.tag = tag; e.count = c; e.disp = d; e.running = r; e.frozen = f; e.wrap = w;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty got 0 entries exp 1");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (bus.count_bcd === e.count) else begin
      errors++;
      $error("FAIL %s count_bcd got %h exp %h", e.tag, bus.count_bcd, e.count);
    end
    checks++;
    assert (bus.disp_bcd === e.disp) else begin
      errors++;
      $error("FAIL %s disp_bcd got %h exp %h", e.tag, bus.disp_bcd, e.disp);
    end
    checks++;
    assert (bus.running === e.running) else begin
      errors++;
      $error("FAIL %s running got %b exp %b", e.tag, bus.running, e.running);
    end
    checks++;
    assert (bus.frozen === e.frozen) else begin
      errors++;
      $error("FAIL %s frozen got %b exp %b", e.tag, bus.frozen, e.frozen);
    end
    checks++;
    assert (bus.wrap === e.wrap) else begin
      errors++;
      $error("FAIL %s wrap got %b exp %b", e.tag, bus.wrap, e.wrap);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start_stop = 1'b0;
    bus.lap = 1'b0;

    step(3);
    expect_out("reset", 12'h000, 12'h000, 1'b0, 1'b0, 1'b0); check();
    reset = 1'b0;
    step(2);

    // Basic counting and carry into the hundreds digit.
    press_ss();
    expect_out("run_099", 12'h099, 12'h099, 1'b1, 1'b0, 1'b0); step(990); check();
    expect_out("run_100", 12'h100, 12'h100, 1'b1, 1'b0, 1'b0); step(10); check();

    // Roll-over from all nines.
    expect_out("run_999", 12'h999, 12'h999, 1'b1, 1'b0, 1'b0); step(8990); check();
    expect_out("pre_wrap", 12'h999, 12'h999, 1'b1, 1'b0, 1'b0); step(9); check();
    expect_out("wrap", 12'h000, 12'h000, 1'b1, 1'b0, 1'b1); step(1); check();
    expect_out("post_wrap", 12'h000, 12'h000, 1'b1, 1'b0, 1'b0); step(1); check();

    // Lap lands on a tick edge: snapshot holds the post-tick value.
    expect_out("pre_lap", 12'h052, 12'h052, 1'b1, 1'b0, 1'b0); step(528); check();
    expect_out("lap_freeze", 12'h053, 12'h053, 1'b1, 1'b1, 1'b0); press_lap(); check();
    expect_out("lap_counting", 12'h073, 12'h053, 1'b1, 1'b1, 1'b0); step(200); check();
    expect_out("lap_release", 12'h073, 12'h073, 1'b1, 1'b0, 1'b0); press_lap(); check();

    // Pause, clear, then a stop that coincides with a tick.
    expect_out("pause", 12'h073, 12'h073, 1'b0, 1'b0, 1'b0); press_ss(); check();
    expect_out("clear", 12'h000, 12'h000, 1'b0, 1'b0, 1'b0); press_lap(); check();
    press_ss();
    expect_out("pre_stop", 12'h026, 12'h026, 1'b1, 1'b0, 1'b0); step(269); check();
    expect_out("stop_tick", 12'h027, 12'h027, 1'b0, 1'b0, 1'b0); press_ss(); check();
    expect_out("paused_hold", 12'h027, 12'h027, 1'b0, 1'b0, 1'b0); step(50); check();
    expect_out("clear2", 12'h000, 12'h000, 1'b0, 1'b0, 1'b0); press_lap(); check();
    press_ss();
    expect_out("resume_9", 12'h000, 12'h000, 1'b1, 1'b0, 1'b0); step(9); check();
    expect_out("resume_10", 12'h001, 12'h001, 1'b1, 1'b0, 1'b0); step(1); check();

    // Both buttons rise together: start_stop wins; held levels repeat nothing.
    step(5);
    bus.start_stop = 1'b1;
    bus.lap = 1'b1;
    expect_out("simul", 12'h001, 12'h001, 1'b0, 1'b0, 1'b0); step(1); check();
    expect_out("held_high", 12'h001, 12'h001, 1'b0, 1'b0, 1'b0); step(20); check();
    bus.start_stop = 1'b0;
    bus.lap = 1'b0;
    step(1);

    // Reach LAP at 314, then asynchronous reset with buttons held through release.
    press_lap();
    press_ss();
    expect_out("pre_lap2", 12'h313, 12'h313, 1'b1, 1'b0, 1'b0); step(3139); check();
    expect_out("lap_314", 12'h314, 12'h314, 1'b1, 1'b1, 1'b0); press_lap(); check();
    reset = 1'b1;
    bus.start_stop = 1'b1;
    bus.lap = 1'b1;
    #2;
    expect_out("async_reset", 12'h000, 12'h000, 1'b0, 1'b0, 1'b0); check();
    step(2);
    reset = 1'b0;
    expect_out("held_release", 12'h000, 12'h000, 1'b0, 1'b0, 1'b0); step(5); check();
    bus.start_stop = 1'b0;
    bus.lap = 1'b0;
    step(2);
    expect_out("restart", 12'h000, 12'h000, 1'b1, 1'b0, 1'b0); press_ss(); check();
    expect_out("restart_tick", 12'h001, 12'h001, 1'b1, 1'b0, 1'b0); step(10); check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
